// File: rtl/bram_log_pkg.sv
// rtl/bram_log_pkg.sv - shared widths, logger entry layout and drain states for the BRAM log drain
package bram_log_pkg;

    localparam int EXT_DATA_BITW = 32;
    localparam int LOG_ID_BITW   = 16;
    localparam int LOG_LEN_BITW  = 16;

    function automatic int entry_bitw(input int num_par_brams);
        return EXT_DATA_BITW * num_par_brams;
    endfunction

    function automatic int entries_max(input int num_ser_brams);
        return 1024 * num_ser_brams;
    endfunction

    // Field order mirrors the logger: timestamp lowest, then addr, id from bit 64, len on top.
    typedef struct packed {
        logic [LOG_LEN_BITW-1:0] len;
        logic [LOG_ID_BITW-1:0]  id;
        logic [31:0]             addr;
        logic [31:0]             timestamp;
    } log_entry_t;

    typedef enum logic [2:0] {
        DS_IDLE   = 3'd0,
        DS_READ   = 3'd1,
        DS_OUTPUT = 3'd2,
        DS_CLEAR  = 3'd3,
        DS_DONE   = 3'd4
    } drain_state_e;

endpackage

// File: rtl/bram_log_rd_seq.sv
// rtl/bram_log_rd_seq.sv - per-entry BRAM word issue counter and read-latency capture pipeline
module bram_log_rd_seq
    import bram_log_pkg::*;
#(
    parameter int NUM_PAR_BRAMS = 3,
    parameter int BRAM_RD_LAT   = 1,
    parameter int CNT_W         = 14
) (
    input  logic                                    Clk_CI,
    input  logic                                    Rst_RBI,
    input  logic                                    i_run,
    input  logic [CNT_W-1:0]                        i_entry,
    output logic                                    o_bram_en,
    output logic [31:0]                             o_bram_addr,
    input  logic [31:0]                             i_bram_rd,
    output logic [EXT_DATA_BITW*NUM_PAR_BRAMS-1:0]  o_entry,
    output logic                                    o_last_cap
);

    localparam int WORD_W = $clog2(NUM_PAR_BRAMS + 1);

    logic [WORD_W-1:0]                       r_word;
    logic [BRAM_RD_LAT-1:0]                  r_vld_pipe;
    logic [WORD_W-1:0]                       r_idx_pipe [BRAM_RD_LAT];
    logic [EXT_DATA_BITW*NUM_PAR_BRAMS-1:0]  r_entry;
    logic                                    w_issue;
    logic [31:0]                             w_word_addr;

    assign w_issue     = i_run && (r_word < WORD_W'(NUM_PAR_BRAMS));
    assign w_word_addr = 32'(i_entry) * 32'(NUM_PAR_BRAMS) + 32'(r_word);
    assign o_bram_en   = w_issue;
    assign o_bram_addr = w_issue ? (w_word_addr << 2) : 32'd0;
    assign o_entry     = r_entry;
    assign o_last_cap  = r_vld_pipe[BRAM_RD_LAT-1] &&
                         (r_idx_pipe[BRAM_RD_LAT-1] == WORD_W'(NUM_PAR_BRAMS - 1));

    // The pipe carries the word index alongside each issued read so the returning data lands in its slot.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_word     <= '0;
            r_vld_pipe <= '0;
            r_entry    <= '0;
            for (int i = 0; i < BRAM_RD_LAT; i++) begin
                r_idx_pipe[i] <= '0;
            end
        end else begin
            if (!i_run || o_last_cap) begin
                r_word <= '0;
            end else if (w_issue) begin
                r_word <= r_word + WORD_W'(1);
            end
            r_vld_pipe[0] <= w_issue;
            r_idx_pipe[0] <= r_word;
            for (int i = 1; i < BRAM_RD_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_idx_pipe[i] <= r_idx_pipe[i-1];
            end
            if (r_vld_pipe[BRAM_RD_LAT-1]) begin
                for (int w = 0; w < NUM_PAR_BRAMS; w++) begin
                    if (r_idx_pipe[BRAM_RD_LAT-1] == WORD_W'(w)) begin
                        r_entry[EXT_DATA_BITW*w +: EXT_DATA_BITW] <= i_bram_rd;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bram_log_drain.sv
// rtl/bram_log_drain.sv - BRAM logger readout drain to a valid/ready stream; option BRAM_LOG_DRAIN_AUTO_CLEAR_EN
module bram_log_drain
    import bram_log_pkg::*;
#(
    parameter int  NUM_PAR_BRAMS = 3,
    parameter int  NUM_SER_BRAMS = 12,
    parameter int  BRAM_RD_LAT   = 1,
    localparam int ENTRIES_MAX   = entries_max(NUM_SER_BRAMS),
    localparam int CNT_W         = $clog2(ENTRIES_MAX + 1),
    localparam int ENTRY_W       = entry_bitw(NUM_PAR_BRAMS)
) (
    input  logic               Clk_CI,
    input  logic               Rst_RBI,
    input  logic               Start_SI,
    input  logic [CNT_W-1:0]   NumEntries_DI,
    output logic               Busy_SO,
    output logic               Done_SO,
    output logic               BramEn_SO,
    output logic [31:0]        BramAddr_DO,
    output logic [3:0]         BramWrEn_SO,
    output logic [31:0]        BramWr_DO,
    input  logic [31:0]        BramRd_DI,
    output logic [ENTRY_W-1:0] Entry_DO,
    output logic               EntryValid_SO,
    input  logic               EntryReady_SI,
    input  logic               LogFull_SI,
    output logic               LogClear_SO
);

    localparam logic [2:0] S_IDLE   = 3'(DS_IDLE);
    localparam logic [2:0] S_READ   = 3'(DS_READ);
    localparam logic [2:0] S_OUTPUT = 3'(DS_OUTPUT);
    localparam logic [2:0] S_CLEAR  = 3'(DS_CLEAR);
    localparam logic [2:0] S_DONE   = 3'(DS_DONE);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_entry;
    logic [CNT_W-1:0] w_num_clamp;
    logic [CNT_W-1:0] w_entry_inc;
    logic             w_accept;
    logic             w_last_cap;
    logic             w_unused;

`ifdef BRAM_LOG_DRAIN_AUTO_CLEAR_EN
    localparam logic [2:0] S_AFTER_LAST = S_CLEAR;
    assign LogClear_SO = (r_state == S_CLEAR);
`else
    localparam logic [2:0] S_AFTER_LAST = S_DONE;
    assign LogClear_SO = 1'b0;
`endif

    assign w_accept    = (r_state == S_IDLE) && Start_SI;
    assign w_num_clamp = (NumEntries_DI > CNT_W'(ENTRIES_MAX)) ? CNT_W'(ENTRIES_MAX) : NumEntries_DI;
    assign w_entry_inc = r_entry + CNT_W'(1);
    assign w_unused    = LogFull_SI;

    // Busy covers the accepting cycle itself; the reset term keeps every output low while in reset.
    assign Busy_SO       = Rst_RBI && (w_accept || (r_state == S_READ) ||
                                       (r_state == S_OUTPUT) || (r_state == S_CLEAR));
    assign Done_SO       = (r_state == S_DONE);
    assign EntryValid_SO = (r_state == S_OUTPUT);
    assign BramWrEn_SO   = 4'd0;
    assign BramWr_DO     = 32'd0;

    bram_log_rd_seq #(
        .NUM_PAR_BRAMS (NUM_PAR_BRAMS),
        .BRAM_RD_LAT   (BRAM_RD_LAT),
        .CNT_W         (CNT_W)
    ) u_rd_seq (
        .Clk_CI      (Clk_CI),
        .Rst_RBI     (Rst_RBI),
        .i_run       (r_state == S_READ),
        .i_entry     (r_entry),
        .o_bram_en   (BramEn_SO),
        .o_bram_addr (BramAddr_DO),
        .i_bram_rd   (BramRd_DI),
        .o_entry     (Entry_DO),
        .o_last_cap  (w_last_cap)
    );

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_entry <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start_SI) begin
                        r_num   <= w_num_clamp;
                        r_entry <= '0;
                        r_state <= (w_num_clamp == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (w_last_cap) begin
                        r_state <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (EntryReady_SI) begin
                        r_entry <= w_entry_inc;
                        r_state <= (w_entry_inc == r_num) ? S_AFTER_LAST : S_READ;
                    end
                end
`ifdef BRAM_LOG_DRAIN_AUTO_CLEAR_EN
                S_CLEAR: begin
                    r_state <= S_DONE;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_log_drain.sv
// tb/tb_bram_log_drain.sv - directed self-checking bench for bram_log_drain
module tb_bram_log_drain;

    localparam int NPAR    = 3;
    localparam int NSER    = 12;
    localparam int LAT     = 1;
    localparam int EMAX    = 1024 * NSER;
    localparam int CNT_W   = $clog2(EMAX + 1);
    localparam int ENTRY_W = 32 * NPAR;
    localparam int CYC_PER = NPAR + LAT + 1;
`ifdef BRAM_LOG_DRAIN_AUTO_CLEAR_EN
    localparam int AC = 1;
`else
    localparam int AC = 0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   num = '0;
    logic               busy, done, bram_en, valid, clear;
    logic               ready = 1'b1;
    logic               full = 1'b0;
    logic [31:0]        bram_addr, bram_wr;
    logic [31:0]        bram_rd = 32'd0;
    logic [3:0]         bram_wren;
    logic [ENTRY_W-1:0] entry;

    int errors = 0;
    int checks = 0;

    int t_got, t_reads, t_first_valid, t_done_cyc, t_clear_cnt, t_clear_cyc;
    logic t_done_seen, t_aborted;
    logic [31:0]        t_last_addr;
    logic [ENTRY_W-1:0] t_entry1;

    bram_log_drain #(
        .NUM_PAR_BRAMS (NPAR),
        .NUM_SER_BRAMS (NSER),
        .BRAM_RD_LAT   (LAT)
    ) dut (
        .Clk_CI        (clk),
        .Rst_RBI       (rst_n),
        .Start_SI      (start),
        .NumEntries_DI (num),
        .Busy_SO       (busy),
        .Done_SO       (done),
        .BramEn_SO     (bram_en),
        .BramAddr_DO   (bram_addr),
        .BramWrEn_SO   (bram_wren),
        .BramWr_DO     (bram_wr),
        .BramRd_DI     (bram_rd),
        .Entry_DO      (entry),
        .EntryValid_SO (valid),
        .EntryReady_SI (ready),
        .LogFull_SI    (full),
        .LogClear_SO   (clear)
    );

    always #5 clk = ~clk;

    // Word w of entry e holds 0x11*(w+1)*(e+1).
    function automatic logic [31:0] pattern(input logic [31:0] wa);
        return 32'h11 * ((wa % NPAR) + 32'd1) * ((wa / NPAR) + 32'd1);
    endfunction

    function automatic logic [ENTRY_W-1:0] exp_entry(input int e);
        logic [ENTRY_W-1:0] v;
        v = '0;
        for (int w = 0; w < NPAR; w++) v[32*w +: 32] = pattern(32'(e * NPAR + w));
        return v;
    endfunction

    always @(posedge clk) if (bram_en) bram_rd <= pattern(bram_addr >> 2);

    task automatic chk(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_drain(input int n_req, input int stall_entry, input int stall_cycles, input int abort_entry);
        int   cyc, budget, stall_left, n_eff;
        logic stalling;
        n_eff = (n_req > EMAX) ? EMAX : n_req;
        budget = (n_eff + 2) * CYC_PER + stall_cycles + 20;
        t_got = 0; t_reads = 0; t_first_valid = -1; t_done_cyc = 0;
        t_clear_cnt = 0; t_clear_cyc = 0; t_done_seen = 1'b0; t_aborted = 1'b0;
        t_last_addr = 32'd0; stall_left = stall_cycles; stalling = 1'b0; cyc = 0;
        @(negedge clk);
        start = 1'b1; num = CNT_W'(n_req); ready = 1'b1;
        #1;
        chk("busy_on_start", busy, 1'b1);
        chk("done_before_start", done, 1'b0);
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (abort_entry >= 0 && t_got == abort_entry && bram_en) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                chk("rst_valid", valid, 1'b0);
                chk("rst_bram_en", bram_en, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_entry", entry, '0);
                chk("rst_addr", bram_addr, 32'd0);
                chk("rst_done", done, 1'b0);
                t_aborted = 1'b1;
                return;
            end
            if (bram_en) begin
                chk("rd_addr", bram_addr, 32'(t_reads) << 2);
                if (t_reads == 0) chk("wr_en_zero", {bram_wren, bram_wr}, 36'd0);
                t_last_addr = bram_addr;
                t_reads++;
            end
            if (stalling && !valid) chk("valid_held", valid, 1'b1);
            if (valid) begin
                if (t_first_valid < 0) t_first_valid = cyc;
                chk("entry", entry, exp_entry(t_got));
                chk("no_rd_in_output", bram_en, 1'b0);
                if (t_got == 1) t_entry1 = entry;
                if (t_got == stall_entry && stall_left > 0) begin
                    stalling = 1'b1;
                    ready = 1'b0;
                    stall_left--;
                end else begin
                    stalling = 1'b0;
                    ready = 1'b1;
                    t_got++;
                end
            end
            if (clear) begin
                t_clear_cnt++;
                t_clear_cyc = cyc;
            end
            if (done) begin
                t_done_cyc = cyc;
                t_done_seen = 1'b1;
                chk("busy_at_done", busy, 1'b0);
                break;
            end
            if (cyc == 1) start = 1'b0;
            if (cyc == 2) begin start = 1'b1; num = CNT_W'(1); end
            if (cyc == 3) start = 1'b0;
        end
        start = 1'b0;
        chk("drain_finished", t_done_seen, 1'b1);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_valid", valid, 1'b0);
        chk("reset_bram_en", bram_en, 1'b0);
        chk("reset_clear", clear, 1'b0);
        chk("reset_entry", entry, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: three entries, consumer always ready
        run_drain(3, -1, 0, -1);
        chk("t1_count", t_got, 3);
        chk("t1_reads", t_reads, 9);
        chk("t1_first_valid", t_first_valid, 5);
        chk("t1_entry1", t_entry1, 96'h00000066_00000044_00000022);
        chk("t1_done_cyc", t_done_cyc, 16 + AC);
        chk("t1_clear_cnt", t_clear_cnt, AC);
        chk("t1_clear_cyc", t_clear_cyc, AC * 16);
        @(negedge clk);
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_done_pulse", done, 1'b0);

        // 2: zero entries
        run_drain(0, -1, 0, -1);
        chk("t2_count", t_got, 0);
        chk("t2_reads", t_reads, 0);
        chk("t2_no_valid", t_first_valid, -1);
        chk("t2_done_cyc", t_done_cyc, 1);
        chk("t2_clear_cnt", t_clear_cnt, 0);

        // 3: two entries, entry 0 stalled for 5 cycles
        run_drain(2, 0, 5, -1);
        chk("t3_count", t_got, 2);
        chk("t3_reads", t_reads, 6);
        chk("t3_first_valid", t_first_valid, 5);
        chk("t3_done_cyc", t_done_cyc, 16 + AC);

        // 4: request above capacity is clamped
        run_drain(EMAX + 7, -1, 0, -1);
        chk("t4_count", t_got, EMAX);
        chk("t4_reads", t_reads, EMAX * NPAR);
        chk("t4_last_addr", t_last_addr, 32'h23FFC);
        chk("t4_done_cyc", t_done_cyc, EMAX * CYC_PER + 1 + AC);
        chk("t4_clear_cnt", t_clear_cnt, AC);

        // 5: reset while reading entry 4 of 10, then a fresh single-entry drain
        run_drain(10, -1, 0, 4);
        chk("t5_aborted", t_aborted, 1'b1);
        chk("t5_got_before_rst", t_got, 4);
        @(negedge clk);
        chk("t5_clear_in_rst", clear, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_drain(1, -1, 0, -1);
        chk("t5_count", t_got, 1);
        chk("t5_reads", t_reads, 3);
        chk("t5_first_valid", t_first_valid, 5);

        // 6: single entry, clear timing
        run_drain(1, -1, 0, -1);
        chk("t6_count", t_got, 1);
        chk("t6_clear_cnt", t_clear_cnt, AC);
        chk("t6_clear_cyc", t_clear_cyc, AC * 6);
        chk("t6_done_cyc", t_done_cyc, 6 + AC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
